// File: rtl/tx_sched_pkg.sv
// Shared definitions for the tx_mux round-robin scheduler.
// State encodings, channel count and per-channel header code.
package tx_sched_pkg;

    localparam int NCH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // tx_mux sends the channel index as the frame header byte.
    function automatic logic [7:0] hdr_code(input logic [1:0] ch);
        return {6'd0, ch};
    endfunction

endpackage

// File: rtl/tx_sched_rr_pick.sv
// Combinational round-robin picker: first set request after ptr.
// Produces a one-hot grant, its index and an any-request flag.
module rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] cand;

    // Scan ptr+1, ptr+2, ptr+3, ptr (mod 4); the first hit wins.
    always_comb begin
        grant = '0;
        idx   = ptr;
        any   = 1'b0;
        cand  = ptr;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + i[1:0];
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_sched.sv
// Round-robin scheduler feeding tx_mux one request at a time.
// Latches producer words, runs req/accept, flags overwrites, counts frames.
module tx_sched
    import tx_sched_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src_valid,
    input  logic [15:0] src_data_0,
    input  logic [15:0] src_data_1,
    input  logic [15:0] src_data_2,
    input  logic [15:0] src_data_3,
    output logic [3:0]  req,
    output logic [15:0] in_0,
    output logic [15:0] in_1,
    output logic [15:0] in_2,
    output logic [15:0] in_3,
    input  logic [3:0]  accept,
    output logic [3:0]  ovf,
    output logic        timeout_err,
    input  logic        err_clr,
    output logic [15:0] frame_cnt
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nx;
    logic [1:0]    rr;
    logic [1:0]    sel;
    logic [3:0]    pend;
    logic [15:0]   hold   [NCH];
    logic [15:0]   data_q [NCH];
    logic [15:0]   src_data [NCH];
    logic [TW-1:0] timer;

    logic [3:0]    pick_grant;
    logic [1:0]    pick_idx;
    logic          pick_any;

    logic          do_grant;
    logic          do_accept;
    logic          do_finish;
    logic [3:0]    gnt_clr;
    logic          tmo_hit;

    assign src_data[0] = src_data_0;
    assign src_data[1] = src_data_1;
    assign src_data[2] = src_data_2;
    assign src_data[3] = src_data_3;

    assign in_0 = data_q[0];
    assign in_1 = data_q[1];
    assign in_2 = data_q[2];
    assign in_3 = data_q[3];

    rr_pick u_pick (
        .req   (pend),
        .ptr   (rr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign gnt_clr = do_grant ? pick_grant : 4'd0;
    assign tmo_hit = (state == REQ) && !do_accept && (timer == TLIM);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and the one-cycle control strobes for the datapath.
    always_comb begin
        state_nx  = state;
        do_grant  = 1'b0;
        do_accept = 1'b0;
        do_finish = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    do_grant = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (accept[sel]) begin
                    do_accept = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                if (accept == 4'd0) begin
                    do_finish = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture path: newest word wins; a refill in the grant cycle is not an overwrite.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 4'd0;
            ovf  <= 4'd0;
            for (int c = 0; c < NCH; c++) hold[c] <= 16'd0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (src_valid[c]) hold[c] <= src_data[c];
            end
            pend <= (pend & ~gnt_clr) | src_valid;
            ovf  <= (err_clr ? 4'd0 : ovf) | (src_valid & pend & ~gnt_clr);
        end
    end

    // Grant path: req and in_x change only at a grant; req drops on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            req <= 4'd0;
            rr  <= 2'd3;
            sel <= 2'd0;
            for (int c = 0; c < NCH; c++) data_q[c] <= 16'd0;
        end else if (do_grant) begin
            req <= pick_grant;
            rr  <= pick_idx;
            sel <= pick_idx;
            for (int c = 0; c < NCH; c++) begin
                data_q[c] <= pick_grant[c] ? hold[c] : 16'd0;
            end
        end else if (do_accept) begin
            req <= 4'd0;
        end
    end

    // Request-age timer; req is kept high past the timeout so the frame survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (do_grant) begin
                timer <= '0;
            end else if (state == REQ && timer != TLIM) begin
                timer <= timer + 1'b1;
            end
            timeout_err <= (timeout_err & ~err_clr) | tmo_hit;
        end
    end

    // Completed-frame counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if (do_finish) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_tx_sched.sv
// Self-checking bench for tx_sched with a behavioural tx_mux and fifo.
// Frames are checked against a round-robin model of pending channels.
module tb_tx_sched;
    import tx_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  src_valid = 4'd0;
    logic [15:0] sd [4];
    logic [3:0]  req;
    logic [15:0] in_0, in_1, in_2, in_3;
    logic [3:0]  accept = 4'd0;
    logic [3:0]  ovf;
    logic        timeout_err;
    logic        err_clr = 1'b0;
    logic [15:0] frame_cnt;
    logic        wfull = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [7:0] fifo [$];

    always #5 clk = ~clk;

    tx_sched #(.TIMEOUT(4096)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_data_0  (sd[0]),
        .src_data_1  (sd[1]),
        .src_data_2  (sd[2]),
        .src_data_3  (sd[3]),
        .req         (req),
        .in_0        (in_0),
        .in_1        (in_1),
        .in_2        (in_2),
        .in_3        (in_3),
        .accept      (accept),
        .ovf         (ovf),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .frame_cnt   (frame_cnt)
    );

    function automatic logic [15:0] in_of(input logic [1:0] c);
        case (c)
            2'd0:    return in_0;
            2'd1:    return in_1;
            2'd2:    return in_2;
            default: return in_3;
        endcase
    endfunction

    function automatic logic [23:0] pop_frame();
        logic [23:0] r;
        r = 24'hxxxxxx;
        if (fifo.size() >= 3) begin
            r[23:16] = fifo.pop_front();
            r[15:8]  = fifo.pop_front();
            r[7:0]   = fifo.pop_front();
        end
        return r;
    endfunction

    // tx_mux model: takes a request, waits out wfull plus a random
    // latency, pulses accept and writes header/hi/lo into the fifo.
    logic       m_busy = 1'b0;
    logic       m_sent = 1'b0;
    logic [1:0] m_ch = 2'd0;
    int         m_lat = 0;
    int         low_cnt = 100;

    always @(negedge clk) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_sent  = 1'b0;
            accept  = 4'd0;
            low_cnt = 100;
        end else begin
            accept = 4'd0;
            checks++;
            if ((req & (req - 4'd1)) != 4'd0) begin
                failures++;
                $display("FAIL req_onehot: req=%b required at most one bit", req);
            end
            if (!m_busy) begin
                if (req != 4'd0) begin
                    checks++;
                    if (low_cnt < 2) begin
                        failures++;
                        $display("FAIL req_gap: low cycles=%0d required >=2", low_cnt);
                    end
                    for (int i = 0; i < 4; i++) if (req[i]) m_ch = 2'(i);
                    m_busy = 1'b1;
                    m_sent = 1'b0;
                    m_lat  = $urandom_range(0, 3);
                end
            end else if (!m_sent) begin
                checks++;
                if (req[m_ch] !== 1'b1) begin
                    failures++;
                    $display("FAIL req_hold: req=%b required bit %0d high", req, m_ch);
                end
                if (!wfull) begin
                    if (m_lat > 0) begin
                        m_lat--;
                    end else begin
                        checks++;
                        if ((in_0 | in_1 | in_2 | in_3) !== in_of(m_ch)) begin
                            failures++;
                            $display("FAIL in_other: in=%h,%h,%h,%h required only ch%0d",
                                     in_0, in_1, in_2, in_3, m_ch);
                        end
                        accept[m_ch] = 1'b1;
                        fifo.push_back(hdr_code(m_ch));
                        fifo.push_back(in_of(m_ch)[15:8]);
                        fifo.push_back(in_of(m_ch)[7:0]);
                        m_sent = 1'b1;
                    end
                end
            end else if (req == 4'd0) begin
                m_busy = 1'b0;
            end
            if (req == 4'd0) low_cnt++;
            else low_cnt = 0;
        end
    end

    task automatic strobe(input logic [3:0] m, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] c,
                          input logic [15:0] d);
        @(negedge clk);
        sd[0] = a; sd[1] = b; sd[2] = c; sd[3] = d;
        src_valid = m;
        @(negedge clk);
        src_valid = 4'd0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        src_valid = 4'd0;
        wfull = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        fifo.delete();
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (fifo.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (fifo.size() < n) begin
            failures++;
            $display("FAIL %s_wait: bytes=%0d required %0d", tag, fifo.size(), n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_req(input int ch, input string tag);
        int k;
        k = 0;
        while (req[ch] !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (req[ch] !== 1'b1) begin
            failures++;
            $display("FAIL %s_req: req=%b required bit %0d", tag, req, ch);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({req, in_0, in_1, in_2, in_3} !== 68'd0) begin
            failures++;
            $display("FAIL reset_out: req=%b in=%h,%h,%h,%h required 0",
                     req, in_0, in_1, in_2, in_3);
        end
        checks++;
        if ({ovf, timeout_err, frame_cnt} !== 21'd0) begin
            failures++;
            $display("FAIL reset_flags: ovf=%b tmo=%b cnt=%h required 0",
                     ovf, timeout_err, frame_cnt);
        end
    endtask

    task automatic test_single();
        logic [23:0] f;
        reset_dut();
        strobe(4'b0100, 16'h0, 16'h0, 16'hBEEF, 16'h0);
        wait_bytes(3, 50, "single");
        f = pop_frame();
        checks++;
        if (f !== 24'h02BEEF) begin
            failures++;
            $display("FAIL single_frame: got %h required 02beef", f);
        end
        checks++;
        if (frame_cnt !== 16'd1 || ovf !== 4'd0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL single_state: cnt=%0d ovf=%b tmo=%b required 1,0,0",
                     frame_cnt, ovf, timeout_err);
        end
    endtask

    task automatic test_fairness();
        logic [23:0] f;
        reset_dut();
        strobe(4'hF, 16'h1000, 16'h1001, 16'h1002, 16'h1003);
        wait_bytes(12, 100, "fair4");
        for (int i = 0; i < 4; i++) begin
            f = pop_frame();
            checks++;
            if (f !== {8'(i), 16'h1000 + 16'(i)}) begin
                failures++;
                $display("FAIL fair4_order: slot %0d got %h required %h",
                         i, f, {8'(i), 16'h1000 + 16'(i)});
            end
        end
        strobe(4'b1001, 16'h2000, 16'h0, 16'h0, 16'h2003);
        wait_bytes(6, 60, "fair2");
        f = pop_frame();
        checks++;
        if (f !== 24'h002000) begin
            failures++;
            $display("FAIL fair2_first: got %h required 002000", f);
        end
        f = pop_frame();
        checks++;
        if (f !== 24'h032003) begin
            failures++;
            $display("FAIL fair2_second: got %h required 032003", f);
        end
        checks++;
        if (frame_cnt !== 16'd6) begin
            failures++;
            $display("FAIL fair_cnt: cnt=%0d required 6", frame_cnt);
        end
    endtask

    task automatic test_overwrite();
        logic [23:0] f;
        reset_dut();
        wfull = 1'b1;
        strobe(4'b0001, 16'hAAAA, 16'h0, 16'h0, 16'h0);
        wait_req(0, "ovw");
        strobe(4'b0010, 16'h0, 16'h1111, 16'h0, 16'h0);
        strobe(4'b0010, 16'h0, 16'h2222, 16'h0, 16'h0);
        checks++;
        if (ovf !== 4'b0010) begin
            failures++;
            $display("FAIL ovw_flag: ovf=%b required 0010", ovf);
        end
        wfull = 1'b0;
        wait_bytes(6, 60, "ovw");
        f = pop_frame();
        checks++;
        if (f !== 24'h00AAAA) begin
            failures++;
            $display("FAIL ovw_ch0: got %h required 00aaaa", f);
        end
        f = pop_frame();
        checks++;
        if (f !== 24'h012222 || fifo.size() != 0) begin
            failures++;
            $display("FAIL ovw_ch1: got %h left=%0d required 012222,0", f, fifo.size());
        end
        checks++;
        if (ovf !== 4'b0010) begin
            failures++;
            $display("FAIL ovw_sticky: ovf=%b required 0010", ovf);
        end
        pulse_clr();
        checks++;
        if (ovf !== 4'b0000) begin
            failures++;
            $display("FAIL ovw_clr: ovf=%b required 0000", ovf);
        end
    endtask

    task automatic test_grant_restrobe();
        logic [23:0] f;
        reset_dut();
        @(negedge clk);
        sd[2] = 16'h1234;
        src_valid = 4'b0100;
        @(negedge clk);
        sd[2] = 16'h5678;
        @(negedge clk);
        src_valid = 4'd0;
        wait_bytes(6, 60, "regrant");
        f = pop_frame();
        checks++;
        if (f !== 24'h021234) begin
            failures++;
            $display("FAIL regrant_first: got %h required 021234", f);
        end
        f = pop_frame();
        checks++;
        if (f !== 24'h025678) begin
            failures++;
            $display("FAIL regrant_second: got %h required 025678", f);
        end
        checks++;
        if (ovf !== 4'd0) begin
            failures++;
            $display("FAIL regrant_ovf: ovf=%b required 0000", ovf);
        end
    endtask

    task automatic test_random();
        logic [3:0]  m;
        logic [15:0] d [4];
        logic [23:0] f;
        int          last;
        int          cnt;
        int          n;
        reset_dut();
        last = 3;
        cnt = 0;
        for (int r = 0; r < 20; r++) begin
            m = 4'($urandom_range(1, 15));
            for (int c = 0; c < 4; c++) d[c] = 16'($urandom);
            strobe(m, d[0], d[1], d[2], d[3]);
            n = 0;
            for (int c = 0; c < 4; c++) if (m[c]) n++;
            wait_bytes(3 * n, 120, "rand");
            for (int i = 1; i <= 4; i++) begin
                int c;
                c = (last + i) % 4;
                if (m[c]) begin
                    f = pop_frame();
                    checks++;
                    if (f !== {8'(c), d[c]}) begin
                        failures++;
                        $display("FAIL rand_frame: round %0d got %h required %h",
                                 r, f, {8'(c), d[c]});
                    end
                    cnt++;
                end
            end
            for (int i = 1; i <= 4; i++) if (m[(last + i) % 4]) n = (last + i) % 4;
            last = n;
        end
        checks++;
        if (frame_cnt !== 16'(cnt) || ovf !== 4'd0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL rand_state: cnt=%0d ovf=%b tmo=%b required %0d,0,0",
                     frame_cnt, ovf, timeout_err, cnt);
        end
    endtask

    task automatic test_timeout();
        logic [23:0] f;
        reset_dut();
        wfull = 1'b1;
        strobe(4'b0010, 16'h0, 16'hC0DE, 16'h0, 16'h0);
        wait_req(1, "tmo");
        repeat (4095) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL tmo_early: tmo=%b required 0", timeout_err);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1 || req !== 4'b0010) begin
            failures++;
            $display("FAIL tmo_set: tmo=%b req=%b required 1,0010", timeout_err, req);
        end
        repeat (900) @(negedge clk);
        wfull = 1'b0;
        wait_bytes(3, 50, "tmo");
        f = pop_frame();
        checks++;
        if (f !== 24'h01C0DE || timeout_err !== 1'b1 || frame_cnt !== 16'd1) begin
            failures++;
            $display("FAIL tmo_frame: got %h tmo=%b cnt=%0d required 01c0de,1,1",
                     f, timeout_err, frame_cnt);
        end
        pulse_clr();
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL tmo_clr: tmo=%b required 0", timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] f;
        reset_dut();
        wfull = 1'b1;
        strobe(4'b1000, 16'h0, 16'h0, 16'h0, 16'h3333);
        wait_req(3, "rmid");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req !== 4'd0 || in_3 !== 16'd0 || frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL rmid_out: req=%b in_3=%h cnt=%0d required 0,0,0",
                     req, in_3, frame_cnt);
        end
        rst = 1'b0;
        wfull = 1'b0;
        fifo.delete();
        strobe(4'b0010, 16'h0, 16'h4321, 16'h0, 16'h0);
        wait_bytes(3, 50, "rmid");
        f = pop_frame();
        checks++;
        if (f !== 24'h014321 || fifo.size() != 0 || frame_cnt !== 16'd1) begin
            failures++;
            $display("FAIL rmid_frame: got %h left=%0d cnt=%0d required 014321,0,1",
                     f, fifo.size(), frame_cnt);
        end
    endtask

    task automatic test_wrap();
        reset_dut();
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        #1;
        checks++;
        if (frame_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preload: cnt=%h required ffff", frame_cnt);
        end
        strobe(4'b0001, 16'h0F0F, 16'h0, 16'h0, 16'h0);
        wait_bytes(3, 50, "wrap");
        checks++;
        if (frame_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_cnt: cnt=%h required 0000", frame_cnt);
        end
    endtask

    initial begin
        for (int c = 0; c < 4; c++) sd[c] = 16'd0;
        test_reset();
        test_single();
        test_fairness();
        test_overwrite();
        test_grant_restrobe();
        test_random();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
